// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction coming out of ID, registered
// instruction going into EX, and the hazard/status signals that travel with it.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // Instruction currently in ID
    logic [4:0]        IF_ID_RS_i;
    logic [4:0]        IF_ID_RT_i;
    logic [4:0]        IF_ID_RD_i;
    logic              IF_ID_uses_rs_i;
    logic              IF_ID_uses_rt_i;
    logic [DATA_W-1:0] RS_data_i;
    logic [DATA_W-1:0] RT_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] pc_plus4_i;
    logic              RegWrite_i;
    logic              MemToReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              Branch_i;
    logic              ALUSrc_i;
    logic              RegDst_i;
    logic [2:0]        ALUOp_i;
    logic              flush_i;

    // Instruction held for EX
    logic [4:0]        ID_EX_RS_o;
    logic [4:0]        ID_EX_RT_o;
    logic [4:0]        ID_EX_RD_o;
    logic [DATA_W-1:0] ID_EX_RS_data_o;
    logic [DATA_W-1:0] ID_EX_RT_data_o;
    logic [DATA_W-1:0] ID_EX_imm_o;
    logic [DATA_W-1:0] ID_EX_pc_plus4_o;
    logic              ID_EX_RegWrite_o;
    logic              ID_EX_MemToReg_o;
    logic              ID_EX_MemRead_o;
    logic              ID_EX_MemWrite_o;
    logic              ID_EX_Branch_o;
    logic              ID_EX_ALUSrc_o;
    logic              ID_EX_RegDst_o;
    logic [2:0]        ID_EX_ALUOp_o;
    logic              ID_EX_valid_o;

    // Front-end enables and event counters
    logic              PC_write_o;
    logic              IF_ID_write_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    // Decode side: drives the ID instruction, observes the stage
    modport master (
        output IF_ID_RS_i, IF_ID_RT_i, IF_ID_RD_i, IF_ID_uses_rs_i, IF_ID_uses_rt_i,
               RS_data_i, RT_data_i, imm_i, pc_plus4_i,
               RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
               RegDst_i, ALUOp_i, flush_i,
        input  ID_EX_RS_o, ID_EX_RT_o, ID_EX_RD_o,
               ID_EX_RS_data_o, ID_EX_RT_data_o, ID_EX_imm_o, ID_EX_pc_plus4_o,
               ID_EX_RegWrite_o, ID_EX_MemToReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
               ID_EX_Branch_o, ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_ALUOp_o,
               ID_EX_valid_o, PC_write_o, IF_ID_write_o, stall_cnt_o, flush_cnt_o
    );

    // Pipeline register side
    modport slave (
        input  IF_ID_RS_i, IF_ID_RT_i, IF_ID_RD_i, IF_ID_uses_rs_i, IF_ID_uses_rt_i,
               RS_data_i, RT_data_i, imm_i, pc_plus4_i,
               RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
               RegDst_i, ALUOp_i, flush_i,
        output ID_EX_RS_o, ID_EX_RT_o, ID_EX_RD_o,
               ID_EX_RS_data_o, ID_EX_RT_data_o, ID_EX_imm_o, ID_EX_pc_plus4_o,
               ID_EX_RegWrite_o, ID_EX_MemToReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
               ID_EX_Branch_o, ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_ALUOp_o,
               ID_EX_valid_o, PC_write_o, IF_ID_write_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on
// stall or branch flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    id_ex_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic hazard;
    logic stall;
    logic bubble;

    // Load in EX whose destination is read by the ID instruction; a flush kills ID so it wins
    always_comb begin
        hazard = bus.ID_EX_MemRead_o & bus.ID_EX_valid_o & (bus.ID_EX_RT_o != 5'd0) &
                 ((bus.IF_ID_uses_rs_i & (bus.ID_EX_RT_o == bus.IF_ID_RS_i)) |
                  (bus.IF_ID_uses_rt_i & (bus.ID_EX_RT_o == bus.IF_ID_RT_i)));
        stall  = hazard & ~bus.flush_i;
        bubble = stall | bus.flush_i;
        bus.PC_write_o    = ~stall;
        bus.IF_ID_write_o = ~stall;
    end

    // Pipeline register: reset and bubbles both clear every field, otherwise capture ID
    always_ff @(posedge clk_i) begin
        if (rst_i || bubble) begin
            bus.ID_EX_RS_o       <= 5'd0;
            bus.ID_EX_RT_o       <= 5'd0;
            bus.ID_EX_RD_o       <= 5'd0;
            bus.ID_EX_RS_data_o  <= {DATA_W{1'b0}};
            bus.ID_EX_RT_data_o  <= {DATA_W{1'b0}};
            bus.ID_EX_imm_o      <= {DATA_W{1'b0}};
            bus.ID_EX_pc_plus4_o <= {DATA_W{1'b0}};
            bus.ID_EX_RegWrite_o <= 1'b0;
            bus.ID_EX_MemToReg_o <= 1'b0;
            bus.ID_EX_MemRead_o  <= 1'b0;
            bus.ID_EX_MemWrite_o <= 1'b0;
            bus.ID_EX_Branch_o   <= 1'b0;
            bus.ID_EX_ALUSrc_o   <= 1'b0;
            bus.ID_EX_RegDst_o   <= 1'b0;
            bus.ID_EX_ALUOp_o    <= 3'd0;
            bus.ID_EX_valid_o    <= 1'b0;
        end else begin
            bus.ID_EX_RS_o       <= bus.IF_ID_RS_i;
            bus.ID_EX_RT_o       <= bus.IF_ID_RT_i;
            bus.ID_EX_RD_o       <= bus.IF_ID_RD_i;
            bus.ID_EX_RS_data_o  <= bus.RS_data_i;
            bus.ID_EX_RT_data_o  <= bus.RT_data_i;
            bus.ID_EX_imm_o      <= bus.imm_i;
            bus.ID_EX_pc_plus4_o <= bus.pc_plus4_i;
            bus.ID_EX_RegWrite_o <= bus.RegWrite_i;
            bus.ID_EX_MemToReg_o <= bus.MemToReg_i;
            bus.ID_EX_MemRead_o  <= bus.MemRead_i;
            bus.ID_EX_MemWrite_o <= bus.MemWrite_i;
            bus.ID_EX_Branch_o   <= bus.Branch_i;
            bus.ID_EX_ALUSrc_o   <= bus.ALUSrc_i;
            bus.ID_EX_RegDst_o   <= bus.RegDst_i;
            bus.ID_EX_ALUOp_o    <= bus.ALUOp_i;
            bus.ID_EX_valid_o    <= 1'b1;
        end
    end

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.stall_cnt_o <= '0;
            bus.flush_cnt_o <= '0;
        end else begin
            if (stall && (bus.stall_cnt_o != CNT_MAX)) begin
                bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
            end
            if (bus.flush_i && (bus.flush_cnt_o != CNT_MAX)) begin
                bus.flush_cnt_o <= bus.flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed hazard/flush/saturation scenarios followed
// by random traffic, all checked against a transaction-level model of the stage.
module tb_id_ex_stage;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        uses_rs, uses_rt;
        logic [31:0] rs_data, rt_data, imm, pc4;
        logic        regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst;
        logic [2:0]  aluop;
        logic        flush;
    } id_t;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc4;
        logic        regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst;
        logic [2:0]  aluop;
        logic        valid;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    ex_t model_ex;
    int  model_stall_cnt;
    int  model_flush_cnt;
    logic obs_pcw;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID instruction onto the bus
    task automatic applyStimulus(input id_t s);
        bus.IF_ID_RS_i      = s.rs;
        bus.IF_ID_RT_i      = s.rt;
        bus.IF_ID_RD_i      = s.rd;
        bus.IF_ID_uses_rs_i = s.uses_rs;
        bus.IF_ID_uses_rt_i = s.uses_rt;
        bus.RS_data_i       = s.rs_data;
        bus.RT_data_i       = s.rt_data;
        bus.imm_i           = s.imm;
        bus.pc_plus4_i      = s.pc4;
        bus.RegWrite_i      = s.regwrite;
        bus.MemToReg_i      = s.memtoreg;
        bus.MemRead_i       = s.memread;
        bus.MemWrite_i      = s.memwrite;
        bus.Branch_i        = s.branch;
        bus.ALUSrc_i        = s.alusrc;
        bus.RegDst_i        = s.regdst;
        bus.ALUOp_i         = s.aluop;
        bus.flush_i         = s.flush;
    endtask

    function automatic id_t randStim(input int reg_max, input int flush_odds);
        id_t s;
        s.rs       = 5'($urandom_range(0, reg_max));
        s.rt       = 5'($urandom_range(0, reg_max));
        s.rd       = 5'($urandom_range(0, 31));
        s.uses_rs  = 1'($urandom_range(0, 1));
        s.uses_rt  = 1'($urandom_range(0, 1));
        s.rs_data  = $urandom;
        s.rt_data  = $urandom;
        s.imm      = $urandom;
        s.pc4      = $urandom;
        s.regwrite = 1'($urandom_range(0, 1));
        s.memtoreg = 1'($urandom_range(0, 1));
        s.memread  = 1'($urandom_range(0, 1));
        s.memwrite = 1'($urandom_range(0, 1));
        s.branch   = 1'($urandom_range(0, 1));
        s.alusrc   = 1'($urandom_range(0, 1));
        s.regdst   = 1'($urandom_range(0, 1));
        s.aluop    = 3'($urandom_range(0, 7));
        s.flush    = ($urandom_range(0, flush_odds - 1) == 0);
        return s;
    endfunction

    function automatic ex_t observedEx();
        ex_t o;
        o.rs       = bus.ID_EX_RS_o;
        o.rt       = bus.ID_EX_RT_o;
        o.rd       = bus.ID_EX_RD_o;
        o.rs_data  = bus.ID_EX_RS_data_o;
        o.rt_data  = bus.ID_EX_RT_data_o;
        o.imm      = bus.ID_EX_imm_o;
        o.pc4      = bus.ID_EX_pc_plus4_o;
        o.regwrite = bus.ID_EX_RegWrite_o;
        o.memtoreg = bus.ID_EX_MemToReg_o;
        o.memread  = bus.ID_EX_MemRead_o;
        o.memwrite = bus.ID_EX_MemWrite_o;
        o.branch   = bus.ID_EX_Branch_o;
        o.alusrc   = bus.ID_EX_ALUSrc_o;
        o.regdst   = bus.ID_EX_RegDst_o;
        o.aluop    = bus.ID_EX_ALUOp_o;
        o.valid    = bus.ID_EX_valid_o;
        return o;
    endfunction

    // Hold reset for n edges with random inputs; everything must read as cleared
    task automatic resetDut(input int n);
        rst = 1'b1;
        repeat (n) begin
            applyStimulus(randStim(31, 2));
            @(posedge clk);
            #1;
        end
        model_ex        = '0;
        model_stall_cnt = 0;
        model_flush_cnt = 0;
        checkOutput("rst_regs", observedEx(), '0);
        checkOutput("rst_pc_write", bus.PC_write_o, 1'b1);
        checkOutput("rst_if_id_write", bus.IF_ID_write_o, 1'b1);
        checkOutput("rst_stall_cnt", bus.stall_cnt_o, '0);
        checkOutput("rst_flush_cnt", bus.flush_cnt_o, '0);
        rst = 1'b0;
    endtask

    // One clock of traffic: check the enables before the edge, the register after it
    task automatic step(input id_t s);
        ex_t  nxt;
        logic exp_stall;
        applyStimulus(s);
        #1;
        exp_stall = model_ex.valid && model_ex.memread && (model_ex.rt != 0) &&
                    ((s.uses_rs && model_ex.rt == s.rs) || (s.uses_rt && model_ex.rt == s.rt)) &&
                    !s.flush;
        obs_pcw = bus.PC_write_o;
        checkOutput("pc_write", bus.PC_write_o, !exp_stall);
        checkOutput("if_id_write", bus.IF_ID_write_o, !exp_stall);
        if (s.flush || exp_stall) begin
            nxt = '0;
        end else begin
            nxt = '{rs: s.rs, rt: s.rt, rd: s.rd, rs_data: s.rs_data, rt_data: s.rt_data,
                    imm: s.imm, pc4: s.pc4, regwrite: s.regwrite, memtoreg: s.memtoreg,
                    memread: s.memread, memwrite: s.memwrite, branch: s.branch,
                    alusrc: s.alusrc, regdst: s.regdst, aluop: s.aluop, valid: 1'b1};
        end
        @(posedge clk);
        #1;
        model_ex = nxt;
        if (exp_stall) model_stall_cnt = (model_stall_cnt < CNT_MAX) ? model_stall_cnt + 1 : CNT_MAX;
        if (s.flush)   model_flush_cnt = (model_flush_cnt < CNT_MAX) ? model_flush_cnt + 1 : CNT_MAX;
        checkOutput("id_ex_regs", observedEx(), model_ex);
        checkOutput("stall_cnt", bus.stall_cnt_o, model_stall_cnt[CNT_W-1:0]);
        checkOutput("flush_cnt", bus.flush_cnt_o, model_flush_cnt[CNT_W-1:0]);
    endtask

    initial begin
        id_t nop, pt, lw, add;

        nop = '0;

        // Reset with random inputs on the bus
        resetDut(2);

        // Plain pass-through of a register-register ALU instruction
        pt = nop;
        pt.rs = 5'd3; pt.rt = 5'd4; pt.rd = 5'd5;
        pt.uses_rs = 1'b1; pt.uses_rt = 1'b1;
        pt.rs_data = 32'h1234; pt.regwrite = 1'b1; pt.aluop = 3'd2;
        step(pt);
        checkOutput("pt_rs", bus.ID_EX_RS_o, 5'd3);
        checkOutput("pt_rs_data", bus.ID_EX_RS_data_o, 32'h1234);
        checkOutput("pt_regwrite", bus.ID_EX_RegWrite_o, 1'b1);
        checkOutput("pt_valid", bus.ID_EX_valid_o, 1'b1);

        // Load-use: lw $8 then add reading $8 stalls exactly one cycle
        lw = nop;
        lw.rs = 5'd1; lw.rt = 5'd8; lw.memread = 1'b1; lw.memtoreg = 1'b1;
        lw.regwrite = 1'b1; lw.alusrc = 1'b1;
        add = nop;
        add.rs = 5'd8; add.rt = 5'd2; add.rd = 5'd9; add.uses_rs = 1'b1;
        add.regwrite = 1'b1; add.regdst = 1'b1; add.aluop = 3'd2; add.rs_data = 32'hABCD;
        step(lw);
        step(add);
        checkOutput("lu_pcw_stall", obs_pcw, 1'b0);
        checkOutput("lu_bubble_valid", bus.ID_EX_valid_o, 1'b0);
        checkOutput("lu_bubble_regwrite", bus.ID_EX_RegWrite_o, 1'b0);
        checkOutput("lu_bubble_memread", bus.ID_EX_MemRead_o, 1'b0);
        step(add);
        checkOutput("lu_pcw_release", obs_pcw, 1'b1);
        checkOutput("lu_add_rs", bus.ID_EX_RS_o, 5'd8);
        checkOutput("lu_add_valid", bus.ID_EX_valid_o, 1'b1);
        checkOutput("lu_stall_cnt", bus.stall_cnt_o, 3'd1);

        // Same pair but the add does not read RS: no stall
        add.uses_rs = 1'b0;
        step(lw);
        step(add);
        checkOutput("nouse_pcw", obs_pcw, 1'b1);
        checkOutput("nouse_valid", bus.ID_EX_valid_o, 1'b1);

        // $0 destination never stalls
        resetDut(2);
        lw.rt = 5'd0;
        add.rs = 5'd0; add.uses_rs = 1'b1;
        step(lw);
        step(add);
        checkOutput("zero_pcw", obs_pcw, 1'b1);
        checkOutput("zero_stall_cnt", bus.stall_cnt_o, 3'd0);

        // Flush coinciding with a hazard: flush wins, PC still writes
        lw.rt = 5'd8;
        add.rs = 5'd8;
        step(lw);
        add.flush = 1'b1;
        step(add);
        checkOutput("fl_pcw", obs_pcw, 1'b1);
        checkOutput("fl_valid", bus.ID_EX_valid_o, 1'b0);
        checkOutput("fl_flush_cnt", bus.flush_cnt_o, 3'd1);
        checkOutput("fl_stall_cnt", bus.stall_cnt_o, 3'd0);

        // Flush alone kills a store
        pt = nop;
        pt.memwrite = 1'b1; pt.rs = 5'd4; pt.rt = 5'd6; pt.flush = 1'b1;
        step(pt);
        checkOutput("fl_memwrite", bus.ID_EX_MemWrite_o, 1'b0);

        // Ten load-use stalls saturate a 3-bit counter at 7
        resetDut(1);
        add.flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(lw);
            step(add);
            step(add);
        end
        checkOutput("sat_stall_cnt", bus.stall_cnt_o, 3'd7);
        resetDut(1);

        // Random traffic over a small register set so hazards are frequent
        for (int i = 0; i < 300; i++) begin
            step(randStim(3, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
